// File: rtl/fetch_stage_pkg.sv
// Shared WISC-15 fetch definitions: opcode field, HLT/NOP encodings, reset PC and FSM states.
package fetch_stage_pkg;

  localparam int          OPC_MSB          = 15;
  localparam int          OPC_LSB          = 12;
  localparam logic [3:0]  HLT_OP           = 4'hF;
  localparam logic [15:0] NOP_WORD         = 16'h0000;
  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  function automatic logic [3:0] opcode_of(input logic [15:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats load; holds when neither is asserted.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] NOP_INSTR = NOP_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        flush,
  input  logic [15:0] instr_d,
  input  logic [15:0] pc_plus1_d,
  output logic [15:0] instr,
  output logic [15:0] pc_plus1,
  output logic        valid
);

  // A flush only squashes instr/valid; pc_plus1 is meaningless while valid=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr    <= NOP_INSTR;
      pc_plus1 <= 16'h0000;
      valid    <= 1'b0;
    end else if (flush) begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (load) begin
      instr    <= instr_d;
      pc_plus1 <= pc_plus1_d;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// WISC-15 IF stage: PC, IM interface, HLT detection and redirect handling.
// Optional FETCH_PERF_CNT_EN adds saturating fetch_cnt/stall_cnt outputs.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter logic [3:0]  HLT_OPCODE = HLT_OP,
  parameter logic [15:0] NOP_INSTR  = NOP_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic [15:0] im_instr,
  output logic [15:0] im_addr,
  output logic        im_rd_en,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc_plus1,
  output logic        if_id_valid,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`endif
);

  fetch_state_t state;
  logic [15:0]  pc;
  logic [15:0]  pc_plus1;
  logic         is_hlt;
  logic         ifid_load;
  logic         ifid_flush;

  assign pc_plus1   = pc + 16'd1;
  assign is_hlt     = (opcode_of(im_instr) == HLT_OPCODE);
  assign im_addr    = pc;
  assign im_rd_en   = (state == RUN) && !stall && rst_n;
  assign ifid_load  = !redirect && !stall && (state == RUN);
  assign ifid_flush = redirect || (!stall && (state == HALTED));

  // Redirect overrides stall and also cancels an HLT fetched in a branch shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      pc     <= RESET_PC;
      halted <= 1'b0;
    end else if (redirect) begin
      state  <= RUN;
      pc     <= redirect_pc;
      halted <= 1'b0;
    end else if (!stall && (state == RUN)) begin
      if (is_hlt) begin
        state  <= HALTED;
        halted <= 1'b1;
      end else begin
        pc <= pc_plus1;
      end
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (ifid_load),
    .flush      (ifid_flush),
    .instr_d    (im_instr),
    .pc_plus1_d (pc_plus1),
    .instr      (if_id_instr),
    .pc_plus1   (if_id_pc_plus1),
    .valid      (if_id_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  // Stalls are not counted while halted so both counters freeze on HLT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= 32'h0;
      stall_cnt <= 32'h0;
    end else begin
      if (ifid_load && (fetch_cnt != 32'hFFFF_FFFF))
        fetch_cnt <= fetch_cnt + 32'd1;
      if (stall && !redirect && (state == RUN) && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then randomized traffic vs. a reference model.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] im_instr;
  logic [15:0] im_addr;
  logic        im_rd_en;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc_plus1;
  logic        if_id_valid;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  logic [15:0] mem [0:65535];

  int checks   = 0;
  int failures = 0;

  logic [15:0] m_pc;
  logic [15:0] m_instr;
  logic [15:0] m_pp1;
  logic        m_valid;
  logic        m_halted;
  logic [31:0] m_fetches;
  logic [31:0] m_stalls;

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .im_instr       (im_instr),
    .im_addr        (im_addr),
    .im_rd_en       (im_rd_en),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus1 (if_id_pc_plus1),
    .if_id_valid    (if_id_valid),
    .halted         (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt      (fetch_cnt),
    .stall_cnt      (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The IM returns the word at the current address; the PC is stable during stalls.
  assign im_instr = mem[im_addr];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_pc      = 16'h0000;
    m_instr   = 16'h0000;
    m_pp1     = 16'h0000;
    m_valid   = 1'b0;
    m_halted  = 1'b0;
    m_fetches = 32'h0;
    m_stalls  = 32'h0;
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, ".im_addr"},  {16'h0, im_addr},        {16'h0, m_pc});
    checkOutput({tag, ".instr"},    {16'h0, if_id_instr},    {16'h0, m_instr});
    checkOutput({tag, ".valid"},    {31'h0, if_id_valid},    {31'h0, m_valid});
    checkOutput({tag, ".halted"},   {31'h0, halted},         {31'h0, m_halted});
    if (m_valid)
      checkOutput({tag, ".pc_plus1"}, {16'h0, if_id_pc_plus1}, {16'h0, m_pp1});
`ifdef FETCH_PERF_CNT_EN
    checkOutput({tag, ".fetch_cnt"}, fetch_cnt, m_fetches);
    checkOutput({tag, ".stall_cnt"}, stall_cnt, m_stalls);
`endif
  endtask

  // One clock: drive inputs, check the combinational IM interface, advance the model, check state.
  task automatic applyStimulus(input string tag, input logic st, input logic rd, input logic [15:0] rpc);
    logic [15:0] word;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    #1;
    checkOutput({tag, ".pre_addr"}, {16'h0, im_addr},  {16'h0, m_pc});
    checkOutput({tag, ".rd_en"},    {31'h0, im_rd_en}, {31'h0, (!m_halted && !st)});
    if (rd) begin
      m_pc     = rpc;
      m_instr  = 16'h0000;
      m_valid  = 1'b0;
      m_halted = 1'b0;
    end else if (st) begin
      if (!m_halted) m_stalls++;
    end else if (!m_halted) begin
      word    = mem[m_pc];
      m_instr = word;
      m_valid = 1'b1;
      m_pp1   = m_pc + 16'd1;
      m_fetches++;
      if (word[15:12] == 4'hF) m_halted = 1'b1;
      else                     m_pc     = m_pc + 16'd1;
    end else begin
      m_instr = 16'h0000;
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    checkState(tag);
  endtask

  initial begin
    logic [15:0] w;
    for (int i = 0; i < 65536; i++) begin
      w = i[15:0];
      mem[i] = {4'h1, w[11:0]};
    end
    mem[16'h0010] = 16'hF000;

    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    modelReset();
    #1;
    checkState("reset");
    checkOutput("reset.rd_en", {31'h0, im_rd_en}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) applyStimulus("run", 1'b0, 1'b0, 16'h0);
    checkOutput("run.pc5", {16'h0, im_addr}, 32'h5);
    for (int i = 0; i < 3; i++) applyStimulus("stall", 1'b1, 1'b0, 16'h0);
    checkOutput("stall.pc", {16'h0, im_addr}, 32'h5);
    applyStimulus("resume", 1'b0, 1'b0, 16'h0);
    checkOutput("resume.pc", {16'h0, im_addr}, 32'h6);

    applyStimulus("redir_stall", 1'b1, 1'b1, 16'h0040);
    checkOutput("redir_stall.pc", {16'h0, im_addr}, 32'h40);
    checkOutput("redir_stall.valid", {31'h0, if_id_valid}, 32'h0);
    applyStimulus("after_redir", 1'b0, 1'b0, 16'h0);

    applyStimulus("to_hlt", 1'b0, 1'b1, 16'h0010);
    applyStimulus("hlt", 1'b0, 1'b0, 16'h0);
    checkOutput("hlt.halted", {31'h0, halted}, 32'h1);
    checkOutput("hlt.instr", {16'h0, if_id_instr}, 32'hF000);
    for (int i = 0; i < 3; i++) applyStimulus("halted", i[0], 1'b0, 16'h0);
    checkOutput("halted.pc", {16'h0, im_addr}, 32'h10);
    applyStimulus("unhalt", 1'b0, 1'b1, 16'h0020);
    applyStimulus("unhalt_run", 1'b0, 1'b0, 16'h0);

    applyStimulus("to_wrap", 1'b0, 1'b1, 16'hFFFF);
    applyStimulus("wrap", 1'b0, 1'b0, 16'h0);
    checkOutput("wrap.pc", {16'h0, im_addr}, 32'h0);
    checkOutput("wrap.pp1", {16'h0, if_id_pc_plus1}, 32'h0);

    applyStimulus("to_33", 1'b0, 1'b1, 16'h0030);
    for (int i = 0; i < 3; i++) applyStimulus("pre_rst", 1'b0, 1'b0, 16'h0);
    checkOutput("pre_rst.pc", {16'h0, im_addr}, 32'h33);
    stall    = 1'b0;
    redirect = 1'b0;
    rst_n    = 1'b0;
    modelReset();
    #1;
    checkState("async_rst");
    checkOutput("async_rst.rd_en", {31'h0, im_rd_en}, 32'h0);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus("restart", 1'b0, 1'b0, 16'h0);
    checkOutput("restart.pc", {16'h0, im_addr}, 32'h4);

    for (int i = 0; i < 65536; i++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 15) != 0 && w[15:12] == 4'hF) w[15:12] = 4'($urandom_range(0, 14));
      mem[i] = w;
    end
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand", ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
